// File: rtl/if_id_queue.sv
// Instruction buffer between fetch and decode: in-order FIFO of instr/PC pairs with flush.
// Optional zero-latency empty bypass is enabled by defining IFQ_BYPASS_EN.
module if_id_queue #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [INSTR_W-1:0]         if_instr,
    input  logic [PC_W-1:0]            if_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [INSTR_W-1:0]         id_instr,
    output logic [PC_W-1:0]            id_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;

    always_comb begin
        empty    = (count_q == '0);
        if_ready = (count_q != FULL);
`ifdef IFQ_BYPASS_EN
        bypass   = empty && if_valid && !flush;
`else
        bypass   = 1'b0;
`endif
        id_valid = (!empty && !flush) || bypass;
        // Pops only drain stored entries; a bypassed entry never touches storage.
        pop      = !empty && !flush && id_ready;
        push     = if_valid && if_ready && !flush;
        wr_en    = push && !(bypass && id_ready);

        if (bypass) begin
            id_instr = if_instr;
            id_pc    = if_pc;
        end else if (!empty) begin
            id_instr = instr_mem[rd_ptr_q];
            id_pc    = pc_mem[rd_ptr_q];
        end else begin
            id_instr = '0;
            id_pc    = '0;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_ptr_q] <= if_instr;
            pc_mem[wr_ptr_q]    <= if_pc;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed fill/drain/stream/flush/reset/bypass plus random traffic.
module tb_if_id_queue;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 16;
    localparam int DEPTH   = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               if_valid = 1'b0;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr = '0;
    logic [PC_W-1:0]    if_pc = '0;
    logic               id_valid;
    logic               id_ready = 1'b0;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;
    logic [$clog2(DEPTH):0] count;

    int   nchk = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;
    ent_t mq[$];

    if_id_queue #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] pc,
                         input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
    endtask

    // Reference model: checks outputs mid-cycle, then advances the queue for the coming edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            int   ecnt;
            bit   byp;
            bit   ev;
            ent_t e;
            ecnt = mq.size();
            byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
            byp  = (ecnt == 0) && if_valid && !flush;
`endif
            ev = ((ecnt != 0) && !flush) || byp;
            chk("if_ready", 64'(if_ready), 64'(ecnt != DEPTH));
            chk("count", 64'(count), 64'(ecnt));
            chk("id_valid", 64'(id_valid), 64'(ev));
            if (byp) begin
                chk("byp_pc", 64'(id_pc), 64'(if_pc));
                chk("byp_instr", 64'(id_instr), 64'(if_instr));
            end else if (ecnt != 0) begin
                e = mq[0];
                chk("id_pc", 64'(id_pc), 64'(e.pc));
                chk("id_instr", 64'(id_instr), 64'(e.instr));
            end else begin
                chk("empty_pc", 64'(id_pc), 64'd0);
                chk("empty_instr", 64'(id_instr), 64'd0);
            end
            if (flush) begin
                mq.delete();
            end else if (!(byp && id_ready)) begin
                if (ev && id_ready && ecnt != 0) void'(mq.pop_front());
                if (if_valid && ecnt != DEPTH) mq.push_back('{instr: if_instr, pc: if_pc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then idle
        #12;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        chk("rst_id_instr", 64'(id_instr), 64'd0);
        chk("rst_id_pc", 64'(id_pc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        drive(0, '0, '0, 0, 0);

        // Fill with decode stalled; fifth request must be refused
        for (int i = 0; i < 4; i++)
            drive(1, 32'hA0 + 32'(i), 16'(4 * i), 0, 0);
        drive(1, 32'hA4, 16'h0010, 0, 0);
        #3 chk("full_count", 64'(count), 64'd4);
        chk("full_if_ready", 64'(if_ready), 64'd0);
        drive(1, 32'hA4, 16'h0010, 0, 0);
        #3 chk("full_hold_count", 64'(count), 64'd4);

        // Drain
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, '0, 1, 0);
            #3 chk("drain_pc", 64'(id_pc), 64'(4 * i));
        end
        drive(0, '0, '0, 1, 0);
        #3 chk("drain_count", 64'(count), 64'd0);
        chk("drain_id_valid", 64'(id_valid), 64'd0);

        // Steady streaming at count=2
        drive(1, 32'hB0, 16'h0020, 0, 0);
        drive(1, 32'hB1, 16'h0024, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'hB2 + 32'(i), 16'h0028 + 16'(4 * i), 1, 0);
            #3 chk("stream_count", 64'(count), 64'd2);
        end
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0);

        // Flush with count=3 and a push in the flush cycle
        for (int i = 0; i < 3; i++) drive(1, 32'hC0 + 32'(i), 16'h0030 + 16'(4 * i), 0, 0);
        drive(1, 32'hC3, 16'h0040, 1, 1);
        #3 chk("flush_id_valid", 64'(id_valid), 64'd0);
        drive(0, '0, '0, 1, 0);
        #3 chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_if_ready", 64'(if_ready), 64'd1);
        chk("post_flush_id_valid", 64'(id_valid), 64'd0);

        // Multi-cycle flush keeps the queue empty
        drive(1, 32'hD0, 16'h0050, 0, 0);
        drive(1, 32'hD1, 16'h0054, 0, 1);
        drive(1, 32'hD2, 16'h0058, 0, 1);
        drive(1, 32'hD3, 16'h005C, 0, 1);
        #3 chk("hold_flush_count", 64'(count), 64'd0);
        drive(0, '0, '0, 1, 0);
        #3 chk("hold_flush_end_count", 64'(count), 64'd0);

        // Async reset mid-stream with count=2
        drive(1, 32'hE0, 16'h0060, 0, 0);
        drive(1, 32'hE1, 16'h0064, 0, 0);
        drive(0, '0, '0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_id_valid", 64'(id_valid), 64'd0);
        chk("async_rst_if_ready", 64'(if_ready), 64'd1);
        mq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty queue, fetch and decode both ready
        drive(1, 32'h0000_0F00, 16'h0100, 1, 0);
        #3;
`ifdef IFQ_BYPASS_EN
        chk("byp_same_valid", 64'(id_valid), 64'd1);
        chk("byp_same_pc", 64'(id_pc), 64'h0100);
        chk("byp_same_count", 64'(count), 64'd0);
        drive(0, '0, '0, 1, 0);
        #3 chk("byp_next_count", 64'(count), 64'd0);
        chk("byp_next_valid", 64'(id_valid), 64'd0);
`else
        chk("nobyp_same_valid", 64'(id_valid), 64'd0);
        drive(0, '0, '0, 1, 0);
        #3 chk("nobyp_next_valid", 64'(id_valid), 64'd1);
        chk("nobyp_next_pc", 64'(id_pc), 64'h0100);
`endif
        drive(0, '0, '0, 1, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        for (int i = 0; i < 6; i++) drive(0, '0, '0, 1, 0);
        #3 chk("final_count", 64'(count), 64'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction buffer between instruction_fetch and the decode stage.
- Absorbs fetched instruction/PC pairs and presents them in order to decode with a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered entries on a pipeline flush (branch/jump redirect).

Parameters:
- INSTR_W, 32, instruction word width in bits
- PC_W, 16, program counter width in bits
- DEPTH, 4, number of entries; a power of 2, minimum 2

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush request from execute/branch logic
- if_valid  input  1  fetch is presenting an instruction
- if_ready  output  1  queue can accept an instruction this cycle
- if_instr  input  INSTR_W  fetched instruction word
- if_pc  input  PC_W  PC of the fetched instruction
- id_valid  output  1  queue is presenting an instruction to decode
- id_ready  input  1  decode accepts the presented instruction
- id_instr  output  INSTR_W  instruction at the queue head
- id_pc  output  PC_W  PC at the queue head
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - read pointer, write pointer and count cleared to 0
  - id_valid=0, if_ready=1
  - id_instr=0, id_pc=0
  - storage contents don't-care
- Push occurs when if_valid && if_ready. Pop occurs when id_valid && id_ready.
- if_ready = (count != DEPTH), derived from registered count only; no dependence on id_ready.
- id_valid = (count != 0) && !flush.
- id_instr/id_pc are the head entry when count != 0, and 0 when empty.
- Latency: an entry pushed in cycle N is visible at id_* in cycle N+1 (base build).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop (allowed whenever 0 < count < DEPTH)
- Full (count==DEPTH):
  - if_ready=0; fetch must hold if_instr/if_pc
  - a pop in this cycle frees a slot and raises if_ready next cycle
- Empty (count==0): id_valid=0; id_ready is ignored.
- Order is strictly FIFO; entries are never reordered or duplicated.
- Flush:
  - pointers and count return to 0 at the next edge
  - a push in the flush cycle is dropped, even though if_ready may be 1
  - id_valid is masked low in the flush cycle, so no pop occurs
  - if_ready is 1 in the cycle after a flush
- Flush held for multiple cycles keeps the queue empty.
- Reset asserted mid-operation clears everything immediately, regardless of flush/push/pop.
- Storage writes use the write pointer only; no write when push is 0.

Optional Feature:
- Macro: IFQ_BYPASS_EN
- With the macro defined, zero-latency bypass when empty:
  - if count==0 && if_valid && !flush, then id_valid=1 and id_instr/id_pc = if_instr/if_pc combinationally
  - if id_ready is also 1, the entry passes straight through; it is not written and count stays 0
  - if id_ready is 0, the entry is written as a normal push (count becomes 1)
- Without the macro, there is no bypass and the 1-cycle push-to-id_valid latency always applies.

Test Plan:
- Reset then idle: after rst_n deasserts, id_valid=0, if_ready=1, count=0, id_instr=0.
- Fill with id_ready=0: push PCs 0x0000, 0x0004, 0x0008, 0x000C with instrs 0xA0..0xA3; count reaches 4 and if_ready=0. A fifth if_valid with 0xA4 is not accepted and count stays 4.
- Drain: id_ready=1 for 4 cycles; id_pc sequence 0x0000, 0x0004, 0x0008, 0x000C; count returns to 0 and id_valid=0.
- Steady streaming: count=2, if_valid=1 and id_ready=1 for 10 cycles with incrementing PCs; count stays 2, output order matches input order, pointers wrap twice.
- Flush with count=3 and if_valid=1 (PC 0x0040):
  - id_valid=0 during the flush cycle
  - next cycle count=0, if_ready=1, and 0x0040 is never presented
- Async reset mid-stream: assert rst_n=0 between edges with count=2; count=0 and id_valid=0 immediately, before the next clk edge.
- IFQ_BYPASS_EN build, queue empty, if_valid=1, id_ready=1, if_pc=0x0100:
  - id_valid=1 and id_pc=0x0100 in the same cycle
  - count remains 0
- Without the macro, the same stimulus gives id_valid=0 in that cycle, then id_pc=0x0100 the next cycle.
